// File: rtl/fns_cac_encoder_seq.sv
// fns_cac_encoder_seq: sequential Fibonacci-numeral-system crosstalk-avoidance
// encoder. A binary word is converted MSB first, one codeword bit per clock,
// by greedy Zeckendorf subtraction of weights W[k] = Fib(k+2). The tsv bus only
// changes on entry to DONE, so TSVs never see a partial codeword.
//
// Ports:
//   clock, reset_n   rising-edge clock, synchronous active-low reset
//   in_valid/in_ready/in_data     input word handshake
//   out_valid/out_ready           output codeword handshake
//   tsv        codeword to the TSV pad ring (bit k weight W[k])
//   out_err    word exceeded FMAX = Fib(TSV_W+2)-1; valid with out_valid
//   busy       FSM not idle
//   ftf_err    sticky adjacent-ones self-check flag
//
// Optional feature: define FNS_FTF_CHECK_EN to build the adjacent-ones checker;
// otherwise ftf_err is tied low.
module fns_cac_encoder_seq #(
    parameter int unsigned TSV_W  = 8,
    parameter int unsigned DATA_W = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TSV_W-1:0]  tsv,
    output logic              out_err,
    output logic              busy,
    output logic              ftf_err
);

    localparam int unsigned RW = (DATA_W > TSV_W) ? DATA_W : TSV_W;
    localparam int unsigned KW = $clog2(TSV_W);

    // Fib(1) = Fib(2) = 1
    function automatic int unsigned fib(input int unsigned n);
        int unsigned a;
        int unsigned b;
        int unsigned t;
        a = 1;
        b = 1;
        for (int unsigned i = 3; i <= n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return b;
    endfunction

    localparam logic [RW-1:0] FMAX = RW'(fib(TSV_W + 2) - 1);

    // Elaboration-time parameter range checks
    if (TSV_W < 3 || TSV_W > 24) begin : g_bad_tsv_w
        $error("fns_cac_encoder_seq: TSV_W=%0d outside 3..24", TSV_W);
    end
    if (DATA_W < 1 || DATA_W > TSV_W) begin : g_bad_data_w
        $error("fns_cac_encoder_seq: DATA_W=%0d outside 1..TSV_W", DATA_W);
    end

    // Constant weight table W[k] = Fib(k+2)
    logic [RW-1:0] weight [TSV_W];
    for (genvar g = 0; g < TSV_W; g++) begin : g_weight
        assign weight[g] = RW'(fib(g + 2));
    end

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     residual_q, residual_d;
    logic [TSV_W-1:0]  shadow_q, shadow_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TSV_W-1:0]  tsv_q, tsv_d;
    logic              err_q, err_d;
    logic              in_ready_q, out_valid_q, busy_q;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            residual_q  <= '0;
            shadow_q    <= '0;
            k_q         <= '0;
            tsv_q       <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            residual_q  <= residual_d;
            shadow_q    <= shadow_d;
            k_q         <= k_d;
            tsv_q       <= tsv_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    // Next-state and datapath logic
    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        shadow_d   = shadow_q;
        k_d        = k_q;
        tsv_d      = tsv_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (RW'(in_data) > FMAX) begin
                        tsv_d   = '0;
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        residual_d = RW'(in_data);
                        shadow_d   = '0;
                        k_d        = KW'(TSV_W - 1);
                        state_d    = CONV;
                    end
                end
            end
            CONV: begin
                if (residual_q >= weight[k_q]) begin
                    shadow_d[k_q] = 1'b1;
                    residual_d    = residual_q - weight[k_q];
                end else begin
                    shadow_d[k_q] = 1'b0;
                end
                if (k_q == '0) begin
                    // Publish the whole codeword at once, bit 0 included
                    tsv_d   = shadow_d;
                    err_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign tsv       = tsv_q;
    assign out_err   = err_q;

`ifdef FNS_FTF_CHECK_EN
    logic ftf_q, ftf_d;
    logic ftf_hit_c;

    // A fresh in-range codeword must never hold two adjacent ones
    assign ftf_hit_c = (state_q == CONV) && (state_d == DONE) &&
                       (|(tsv_d & (tsv_d >> 1)));

    always_comb begin
        ftf_d = ftf_q;
        if (ftf_hit_c) begin
            ftf_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ftf_q <= 1'b0;
        end else begin
            ftf_q <= ftf_d;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (reset_n && ftf_hit_c) begin
            $error("fns_cac_encoder_seq: adjacent ones in codeword %b", tsv_d);
        end
    end
`endif

    assign ftf_err = ftf_q;
`else
    assign ftf_err = 1'b0;
`endif

endmodule

// File: doc/fns_cac_encoder_seq.md
Name: fns_cac_encoder_seq

Overview:
- Parametrised, multi-cycle successor to the fixed 4-wire CAC coder.
- Converts a binary word into a Fibonacci-numeral-system (FNS) crosstalk-avoidance codeword driven onto TSV_W through-silicon vias.
- Greedy Zeckendorf conversion: one codeword bit per clock, MSB first.
- Valid/ready handshakes on input and output; out-of-range detection; TSV bus held stable between words.
- Sits between the core-side data register and the TSV pad ring.

Parameters:
TSV_W, 8, number of TSV wires / codeword bits; legal 3..24.
DATA_W, 6, input word width; legal 1..TSV_W; values above FMAX = Fib(TSV_W+2)-1 are out of range.

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  block can accept a word
in_data  in  DATA_W  binary word to encode
out_valid  out  1  tsv holds a new codeword awaiting acceptance
out_ready  in  1  downstream accepts the codeword
tsv  out  TSV_W  codeword driven to TSVs; bit k carries weight W[k]
out_err  out  1  current output word was out of range; valid only with out_valid
busy  out  1  FSM not in IDLE
ftf_err  out  1  sticky self-check flag; see Optional Feature

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous, active-low (`reset_n`), sampled on the rising edge.
- Weights: W[k] = Fib(k+2), i.e. 1, 2, 3, 5, 8, 13, 21, 34, ...
  - Computed at elaboration by a constant function; no runtime table load.
- Reset values: state = IDLE, in_ready = 1, out_valid = 0, out_err = 0, busy = 0, tsv = 0, ftf_err = 0, internal residual/shadow/index = 0.
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, if in_data <= FMAX: residual <= zero-extended in_data; shadow <= 0; k <= TSV_W-1; go to CONV.
  - On in_valid & in_ready, if in_data > FMAX: tsv <= 0; out_err <= 1; go to DONE, skipping CONV.
- CONV:
  - in_ready = 0.
  - Each cycle, if residual >= W[k]: shadow[k] <= 1 and residual <= residual - W[k]; otherwise shadow[k] <= 0.
  - When k == 0: tsv <= final shadow (including bit 0); out_err <= 0; go to DONE. Otherwise k <= k-1.
  - Exactly TSV_W cycles are spent in CONV.
- DONE:
  - out_valid = 1; in_ready = 0.
  - On out_ready, go to IDLE.
  - No new word is accepted in the same cycle as the output handshake.
- Latency: out_valid rises TSV_W+1 clocks after the accepting edge (1 clock for the out-of-range path).
  - Minimum period per word: TSV_W+2 clocks.
- tsv stability:
  - tsv changes only on entry to DONE.
  - It holds its value through IDLE and CONV, so no partial codewords reach the TSVs.
- Arithmetic width:
  - Residual and comparisons use RW = max(DATA_W, TSV_W) bits, unsigned.
  - Because Fib(n+1) < 2^n, every W[k] fits in TSV_W bits.
- Codeword property: greedy conversion guarantees no two adjacent 1s in tsv.
- Boundary conditions:
  - in_data = 0 gives all-zero tsv.
  - in_data = FMAX gives alternating 1010..., MSB set.
  - Back-pressure: out_ready held low keeps DONE, tsv and out_err stable indefinitely.
  - in_valid while not in IDLE is ignored; the source must hold in_valid and in_data until the handshake.
- Reset mid-operation: reset_n low in any state returns all reset values on the next edge. The partial conversion is discarded and tsv is cleared.
- Illegal parameters: an elaboration-time $error is raised if TSV_W or DATA_W is outside its legal range.

Optional Feature:
- Macro: FNS_FTF_CHECK_EN.
- Defined: on every DONE entry without out_err, the block checks tsv for any adjacent pair tsv[k] & tsv[k+1].
  - A violation sets ftf_err, which is sticky until reset.
  - In simulation builds it also issues $error.
- Undefined: the checker logic is omitted and ftf_err is tied to 0.
- The port is present in both builds.

Test Plan (TSV_W=8, DATA_W=6, FMAX=54):
- Reset: hold reset_n low for 3 clocks with in_valid=1 -> tsv=0x00, out_valid=0, in_ready=1, busy=0 after release.
- Encode 54 -> out_valid 9 clocks after accept; tsv=10101010; out_err=0. Encode 33 -> tsv=01010101.
- Encode 20 -> tsv=00101010. Encode 7 -> tsv=00001010. Encode 0 -> tsv=00000000.
- Out of range: encode 55 and 63 -> out_valid 1 clock after accept; tsv=0; out_err=1.
- Back-pressure: hold out_ready=0 for 20 clocks after encoding 20 -> tsv and out_valid stable; in_ready=0; a second in_valid is not accepted until one clock after the output handshake.
- Reset mid-CONV (4 clocks into encoding 54) -> next edge tsv=0, state IDLE. Exhaustive sweep 0..54 with a decoder model -> every round-trip equal, ftf_err=0, no adjacent 1s.
